ifu: RTL
========

# ifu

Instruction fetch unit: owns the architectural PC register and drives the instruction-memory fetch handshake. It publishes the current `pc` to the next-PC calculator and, when decode accepts the fetched instruction, loads that calculator's `npc` result as the new PC. It sits between instruction memory and decode, ahead of the combinational next-PC logic, and is the only stateful element on the PC path.

## Interface
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `npc_in`, input, 32: next PC from the next-PC calculator. Sampled only on an accept cycle.
- `pc`, output, 32: current PC, fed to the next-PC calculator and to decode.
- `imem_req`, output, 1: fetch request.
- `imem_addr`, output, 32: fetch address; always equals `pc`.
- `imem_ack`, input, 1: memory has data this cycle. Meaningful only while `imem_req`=1.
- `imem_rdata`, input, 32: instruction word, valid when `imem_ack`=1.
- `ins`, output, 32: registered instruction word to decode.
- `ins_valid`, output, 1: `ins` holds an unconsumed instruction.
- `ins_ready`, input, 1: decode accepts `ins` this cycle.
- `ins_count`, output, 32: number of instructions accepted since reset.
- `addr_err`, output, 1: sticky misaligned-next-PC flag. Present only with `IFU_ALIGN_CHECK_EN`; otherwise tied to 0.

## Operation
The unit has three states: FETCH, HOLD and ERR.

- **Reset values** (after any cycle with `rst`=1):
  - State FETCH, `pc`=`RESET_PC`, `ins`=0, `ins_valid`=0, `ins_count`=0, `addr_err`=0.
  - `imem_req` goes to 1 in the first cycle after reset.
- **FETCH:**
  - Drive `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1: at the clock edge, capture `ins`<=`imem_rdata`, set `ins_valid`<=1 and move to HOLD.
  - On `imem_ack`=0: stay in FETCH and hold the request and address stable.
- **HOLD:**
  - Drive `imem_req`=0 and keep `ins_valid`=1.
  - An accept cycle is one with `ins_valid` & `ins_ready`.
  - On an accept: at the clock edge, `pc`<=`npc_in`, `ins_count`<=`ins_count`+1 (wraps 32'hFFFF_FFFF to 0), `ins_valid`<=0, and the state returns to FETCH.
  - Without an accept: `ins` and `pc` are unchanged.
- **ERR** (exists only with the macro): see Configuration.
- **Ignored inputs:**
  - `imem_ack` outside FETCH, and `ins_ready` outside HOLD, have no effect.
  - `imem_rdata` is ignored when `imem_ack`=0.
- **`npc_in` timing:** `pc` changes only on an accept. `npc_in` may therefore depend combinationally on `pc` and on the decoded `ins`.
- **Reset priority:** `rst` mid-operation (FETCH wait, HOLD, ERR) overrides everything in that cycle, including a simultaneous `imem_ack` or accept. Captured data and count are discarded.

## Timing
- **Fetch request:** `imem_req` is a combinational decode of state. It is high exactly in FETCH and never in the same cycle as `ins_valid`=1.
- **Zero-wait memory:** with `imem_ack` high in the request cycle, `ins_valid` rises one cycle after the request.
- **Minimum throughput:** 2 cycles per instruction, one in FETCH and one in HOLD with `ins_ready`=1.
- **Memory wait states:** N cycles of `imem_ack`=0 add N cycles in FETCH.
- **New PC:** the new `pc` is visible on `imem_addr` in the cycle immediately after the accept.
- **Count update:** `ins_count` updates on the same edge as `pc`.

## Configuration
- **`IFU_ALIGN_CHECK_EN` defined:**
  - On an accept with `npc_in[1:0]`!=2'b00, the unit moves to ERR instead of FETCH.
  - `addr_err`<=1, `pc` is left unchanged (still the faulting instruction's PC), `ins_valid`<=0, and `ins_count` still increments.
  - In ERR: `imem_req`=0, `ins_valid`=0, `addr_err`=1.
  - The only exit from ERR is `rst`.
- **Undefined:**
  - There is no ERR state and `addr_err` is constant 0.
  - On an accept, `pc`<={`npc_in[31:2]`,2'b00}, i.e. low bits are forced to zero.

## Test plan
- **Reset/first fetch:** reset with `RESET_PC` default. Expect `imem_req`=1, `imem_addr`=32'h0000_3000 and `ins_valid`=0 in the first cycle after `rst` falls.
- **Zero-wait sequential fetch:**
  - Setup: `imem_ack` always 1, `ins_ready` always 1, `npc_in`=`pc`+4.
  - Expect addresses 3000, 3004, 3008 on every other cycle and `ins_count`=3 after the third accept.
- **Memory wait:** hold `imem_ack`=0 for 3 cycles, then return `imem_rdata`=32'h2408_0005. Expect `imem_addr` stable for all 4 cycles, then `ins`=32'h2408_0005 with `ins_valid`=1.
- **Decode stall then jump:**
  - Hold `ins_ready`=0 for 2 cycles. Expect `ins` and `pc` unchanged.
  - Then accept with `npc_in`=32'h0000_3040. Expect the next `imem_addr`=32'h0000_3040.
- **Misaligned next PC:** accept with `npc_in`=32'h0000_3042.
  - With the macro: `addr_err`=1, `imem_req` stuck at 0, `pc` unchanged.
  - Without the macro: next `imem_addr`=32'h0000_3040.
- **Reset overlaps events:** assert `rst` in the same cycle as `imem_ack`=1, and separately in the same cycle as an accept. Expect the reset values and no capture or count increment.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: holds the architectural PC and runs the
// instruction-memory fetch handshake toward decode.
// Optional feature macro: IFU_ALIGN_CHECK_EN (misaligned next-PC trap).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | imem_req high at imem_addr=pc, waiting for imem_ack
// S_HOLD  | instruction captured in ins, waiting for decode to accept
// S_ERR   | misaligned next PC seen; parked until rst (macro builds only)
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_in,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_count,
    output logic        addr_err
);

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_ERR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1
    } state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic        capture;
    logic        accept;
    logic        load_pc;
    logic [31:0] pc_next;

`ifdef IFU_ALIGN_CHECK_EN
    logic        misalign;
    logic        addr_err_q;

    assign misalign = (npc_in[1:0] != 2'b00);
    assign pc_next  = npc_in;
`else
    // Low PC bits are simply dropped when no alignment trap exists.
    assign pc_next  = npc_in & 32'hFFFF_FFFC;
`endif

    assign imem_addr = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, fetch request and datapath enables.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        load_pc    = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ins_valid && ins_ready) begin
                    accept     = 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
                    if (misalign) begin
                        state_next = S_ERR;
                    end else begin
                        load_pc    = 1'b1;
                        state_next = S_FETCH;
                    end
`else
                    load_pc    = 1'b1;
                    state_next = S_FETCH;
`endif
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            S_ERR: begin
                state_next = S_ERR;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // PC, captured instruction, valid flag and accept counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ins       <= 32'h0;
            ins_valid <= 1'b0;
            ins_count <= 32'h0;
        end else begin
            if (capture) begin
                ins       <= imem_rdata;
                ins_valid <= 1'b1;
            end
            if (accept) begin
                ins_valid <= 1'b0;
                ins_count <= ins_count + 32'd1;
            end
            if (load_pc) begin
                pc <= pc_next;
            end
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    // Sticky flag for a misaligned next PC; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else if (accept && misalign) begin
            addr_err_q <= 1'b1;
        end
    end

    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

endmodule
